enigma_cipher_engine: RTL and testbench
=======================================

ENIGMA_CIPHER_ENGINE -- requirements
Module: enigma_cipher_engine

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 cfg_load  input  1  loads r1/r2/r3 start positions; honoured only in IDLE.
REQ-004 r1_position, r2_position, r3_position  input  5 each  start positions 0..25; r1 fast/right slot, r3 slow/left slot.
REQ-005 in_valid  input  1, in_ready  output  1, data_in  input  5  plaintext letter 0..25 (A=0).
REQ-006 out_valid  output  1, out_ready  input  1, data_out  output  5, out_err  output  1  ciphertext letter plus invalid-input flag.
REQ-007 pos_r1, pos_r2, pos_r3  output  5 each  current rotor positions.

Function
REQ-008 Fixed machine: slot r3 = rotor I (notch Q=16), r2 = rotor II (notch E=4), r1 = rotor III (notch V=21), reflector B, ring settings all 0.
REQ-009 FSM states: IDLE, STEP, FWD, REV, DONE; in_ready = 1 only in IDLE.
REQ-010 IDLE: if cfg_load, positions <- r1/r2/r3_position (values >25 reduced mod 26); if in_valid also high in the same cycle, load takes priority and the letter is not accepted.
REQ-011 IDLE to STEP on in_valid & in_ready; data_in registered.
REQ-012 data_in > 25: no stepping, data_out = data_in, out_err = 1, go directly to DONE.
REQ-013 STEP: r1 always advances; r2 advances if r1 is at notch V or r2 is at notch E (double step); r3 advances if r2 is at notch E; each position wraps 25 -> 0.
REQ-014 FWD: letter passes r1, r2, r3 forward then reflector B, using the new positions; result registered.
REQ-015 REV: letter passes r3, r2, r1 through inverse wirings; result registered into data_out.
REQ-016 Rotor transform at position p: out = (W[(x+p) mod 26] - p) mod 26, computed in 6-bit arithmetic with explicit wrap to 0..25.
REQ-017 DONE: out_valid = 1 and data_out/out_err are held stable until out_ready; on out_valid & out_ready, return to IDLE.
REQ-018 Latency: out_valid rises exactly 4 cycles after the accepting edge for valid letters and 1 cycle after for invalid letters, unless backpressured.
REQ-019 Throughput: at most one letter per 5 cycles; no new letter is accepted while out_valid is high.
REQ-020 The machine is self-reciprocal: from identical start positions, encrypting the ciphertext returns the plaintext.

Reset
REQ-021 rst asynchronously forces IDLE, all positions 0, data_out 0, out_valid 0, out_err 0, and in_ready 1 after release.
REQ-022 rst mid-operation aborts the letter in flight; no output is produced for it.

Structure
REQ-023 enigma_pkg SHALL hold the forward and inverse wiring tables for rotors I/II/III, reflector B, the notch constants, the ALPHA=26 constant, and the state enum.
REQ-024 A single combinational sub-module, enigma_rotor_map (inputs: letter, position, rotor select, direction), SHALL be instantiated per slot and reused by the forward and reverse paths.

Verification
REQ-025 Reset, positions 0/0/0, send A,A,A,A,A -> data_out B,D,Z,G,O (1,3,25,6,14); final pos r3/r2/r1 = 0/0/5.
REQ-026 Load r3/r2/r1 = 0/3/20 (ADU), send three letters -> positions after each: ADV, AEW, BFX (double step).
REQ-027 Reload 0/0/0, send B,D,Z,G,O -> A,A,A,A,A (reciprocity).
REQ-028 data_in = 26 -> out_err = 1, data_out = 26, positions unchanged, out_valid 1 cycle after acceptance.
REQ-029 Hold out_ready low for 10 cycles in DONE -> data_out stable, in_ready 0; assert rst during FWD -> IDLE, positions 0, out_valid never rises.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants, wiring tables and types for the three-rotor Enigma engine.
// Fixed machine: rotors I/II/III left-to-right, reflector B, all rings at 0.
package enigma_pkg;

  localparam int unsigned ALPHA = 26;
  localparam int unsigned LW    = 5;

  typedef logic [LW-1:0] letter_t;

  typedef enum logic [1:0] {ROTOR_I, ROTOR_II, ROTOR_III} rotor_e;
  typedef enum logic {DIR_FWD, DIR_REV} dir_e;
  typedef enum logic [2:0] {S_IDLE, S_STEP, S_FWD, S_REV, S_DONE} state_e;

  localparam letter_t NOTCH_I   = 5'd16;
  localparam letter_t NOTCH_II  = 5'd4;
  localparam letter_t NOTCH_III = 5'd21;

  localparam letter_t ROTOR_I_FWD [ALPHA] = '{
    5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  localparam letter_t ROTOR_I_INV [ALPHA] = '{
    5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
    5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
  localparam letter_t ROTOR_II_FWD [ALPHA] = '{
    5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
    5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
  localparam letter_t ROTOR_II_INV [ALPHA] = '{
    5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
  localparam letter_t ROTOR_III_FWD [ALPHA] = '{
    5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
    5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
  localparam letter_t ROTOR_III_INV [ALPHA] = '{
    5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
    5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};
  localparam letter_t REFLECTOR_B [ALPHA] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};

  // Single conditional subtract: every caller keeps its operand below 2*ALPHA.
  function automatic letter_t mod26(input logic [5:0] v);
    mod26 = (v >= 6'(ALPHA)) ? letter_t'(v - 6'(ALPHA)) : letter_t'(v);
  endfunction

  function automatic letter_t inc26(input letter_t v);
    inc26 = (v == letter_t'(ALPHA - 1)) ? '0 : letter_t'(v + 5'd1);
  endfunction

  function automatic letter_t notch_of(input rotor_e r);
    case (r)
      ROTOR_I:  notch_of = NOTCH_I;
      ROTOR_II: notch_of = NOTCH_II;
      default:  notch_of = NOTCH_III;
    endcase
  endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// Combinational single-rotor substitution at a given position, either direction.
module enigma_rotor_map
  import enigma_pkg::*;
(
  input  letter_t letter,
  input  letter_t position,
  input  rotor_e  rotor_sel,
  input  dir_e    dir,
  output letter_t mapped_c
);

  letter_t idx;
  letter_t wired;

  always_comb begin
    idx   = mod26(6'(letter) + 6'(position));
    wired = idx;
    case (rotor_sel)
      ROTOR_I:   wired = (dir == DIR_FWD) ? ROTOR_I_FWD[idx]   : ROTOR_I_INV[idx];
      ROTOR_II:  wired = (dir == DIR_FWD) ? ROTOR_II_FWD[idx]  : ROTOR_II_INV[idx];
      ROTOR_III: wired = (dir == DIR_FWD) ? ROTOR_III_FWD[idx] : ROTOR_III_INV[idx];
      default:   wired = idx;
    endcase
    // Adding ALPHA before subtracting keeps the 6-bit difference non-negative.
    mapped_c = mod26(6'(wired) + 6'(ALPHA) - 6'(position));
  end

endmodule

// File: rtl/enigma_cipher_engine.sv
// Three-rotor Enigma (I/II/III, reflector B) with valid/ready letter streaming.
// One letter per pass through IDLE -> STEP -> FWD -> REV -> DONE.
module enigma_cipher_engine
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_load,
  input  logic [4:0] r1_position,
  input  logic [4:0] r2_position,
  input  logic [4:0] r3_position,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] data_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] data_out,
  output logic       out_err,
  output logic [4:0] pos_r1,
  output logic [4:0] pos_r2,
  output logic [4:0] pos_r3
);

  state_e  state_q, state_d;
  letter_t pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
  letter_t letter_q, letter_d;
  letter_t data_out_q, data_out_d;
  logic    out_err_q, out_err_d;

  // Stage order flips in REV so the same three maps serve both passes.
  logic    rev;
  dir_e    dir;
  rotor_e  s0_rotor, s2_rotor;
  letter_t s0_pos, s2_pos;
  letter_t s0_out, s1_out, s2_out;

  assign rev      = (state_q == S_REV);
  assign dir      = rev ? DIR_REV : DIR_FWD;
  assign s0_rotor = rev ? ROTOR_I : ROTOR_III;
  assign s0_pos   = rev ? pos3_q : pos1_q;
  assign s2_rotor = rev ? ROTOR_III : ROTOR_I;
  assign s2_pos   = rev ? pos1_q : pos3_q;

  enigma_rotor_map u_stage0 (.letter(letter_q), .position(s0_pos), .rotor_sel(s0_rotor),
                             .dir(dir), .mapped_c(s0_out));
  enigma_rotor_map u_stage1 (.letter(s0_out), .position(pos2_q), .rotor_sel(ROTOR_II),
                             .dir(dir), .mapped_c(s1_out));
  enigma_rotor_map u_stage2 (.letter(s1_out), .position(s2_pos), .rotor_sel(s2_rotor),
                             .dir(dir), .mapped_c(s2_out));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pos1_q     <= '0;
      pos2_q     <= '0;
      pos3_q     <= '0;
      letter_q   <= '0;
      data_out_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos1_q     <= pos1_d;
      pos2_q     <= pos2_d;
      pos3_q     <= pos3_d;
      letter_q   <= letter_d;
      data_out_q <= data_out_d;
      out_err_q  <= out_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos1_d     = pos1_q;
    pos2_d     = pos2_q;
    pos3_d     = pos3_q;
    letter_d   = letter_q;
    data_out_d = data_out_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          pos1_d = mod26({1'b0, r1_position});
          pos2_d = mod26({1'b0, r2_position});
          pos3_d = mod26({1'b0, r3_position});
        end else if (in_valid) begin
          letter_d = data_in;
          if (data_in > letter_t'(ALPHA - 1)) begin
            data_out_d = data_in;
            out_err_d  = 1'b1;
            state_d    = S_DONE;
          end else begin
            out_err_d = 1'b0;
            state_d   = S_STEP;
          end
        end
      end
      S_STEP: begin
        // Middle rotor double-steps off its own notch.
        pos1_d = inc26(pos1_q);
        if (pos1_q == notch_of(ROTOR_III) || pos2_q == notch_of(ROTOR_II)) pos2_d = inc26(pos2_q);
        if (pos2_q == notch_of(ROTOR_II)) pos3_d = inc26(pos3_q);
        state_d = S_FWD;
      end
      S_FWD: begin
        letter_d = REFLECTOR_B[s2_out];
        state_d  = S_REV;
      end
      S_REV: begin
        data_out_d = s2_out;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign data_out  = data_out_q;
  assign out_err   = out_err_q;
  assign pos_r1    = pos1_q;
  assign pos_r2    = pos2_q;
  assign pos_r3    = pos3_q;

endmodule

// File: tb/tb_enigma_cipher_engine.sv
// Directed self-checking bench for enigma_cipher_engine.
module tb_enigma_cipher_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [4:0] r1_position, r2_position, r3_position;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] data_out;
  logic       out_err;
  logic [4:0] pos_r1, pos_r2, pos_r3;

  int tests = 0;
  int fails = 0;

  enigma_cipher_engine dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load),
    .r1_position(r1_position), .r2_position(r2_position), .r3_position(r3_position),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .out_err(out_err),
    .pos_r1(pos_r1), .pos_r2(pos_r2), .pos_r3(pos_r3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int p3, input int p2, input int p1);
    pk = 16'({5'(p3), 5'(p2), 5'(p1)});
  endfunction

  function automatic logic [15:0] cur_pos();
    cur_pos = 16'({pos_r3, pos_r2, pos_r1});
  endfunction

  task automatic load(input int p3, input int p2, input int p1, input logic with_valid);
    r3_position = 5'(p3);
    r2_position = 5'(p2);
    r1_position = 5'(p1);
    cfg_load    = 1'b1;
    in_valid    = with_valid;
    data_in     = 5'd0;
    tick();
    cfg_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // Accept one letter, check latency and result, then drain it.
  task automatic send(input string tag, input logic [4:0] l, input logic [4:0] exp_out,
                      input logic chk_out);
    check({tag, "_rdy"}, 16'(in_ready), 16'd1);
    in_valid = 1'b1;
    data_in  = l;
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 16'(in_ready), 16'd0);
    tick();
    tick();
    check({tag, "_early"}, 16'(out_valid), 16'd0);
    tick();
    check({tag, "_vld"}, 16'(out_valid), 16'd1);
    check({tag, "_err"}, 16'(out_err), 16'd0);
    if (chk_out) check({tag, "_out"}, 16'(data_out), 16'(exp_out));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 16'(out_valid), 16'd0);
  endtask

  initial begin
    logic [4:0] pt [5];
    logic [4:0] ct [5];
    pt = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    ct = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};

    rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; r1_position = '0; r2_position = '0; r3_position = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_data_out", 16'(data_out), 16'd0);
    check("rst_out_err", 16'(out_err), 16'd0);
    check("rst_pos", cur_pos(), pk(0, 0, 0));

    // AAAAA from AAA -> BDZGO
    for (int i = 0; i < 5; i++) send($sformatf("aaa%0d", i), pt[i], ct[i], 1'b1);
    check("aaa_pos", cur_pos(), pk(0, 0, 5));

    // Double step from ADU
    load(0, 3, 20, 1'b0);
    check("adu_load", cur_pos(), pk(0, 3, 20));
    send("adu0", 5'd0, 5'd0, 1'b0);
    check("adu_pos0", cur_pos(), pk(0, 3, 21));
    send("adu1", 5'd0, 5'd0, 1'b0);
    check("adu_pos1", cur_pos(), pk(0, 4, 22));
    send("adu2", 5'd0, 5'd0, 1'b0);
    check("adu_pos2", cur_pos(), pk(1, 5, 23));

    // Out-of-range start position wraps; load wins over a simultaneous letter
    load(0, 0, 27, 1'b0);
    check("load_mod", cur_pos(), pk(0, 0, 1));
    load(0, 0, 0, 1'b1);
    check("load_prio_pos", cur_pos(), pk(0, 0, 0));
    check("load_prio_rdy", 16'(in_ready), 16'd1);
    tick();
    check("load_prio_novld", 16'(out_valid), 16'd0);

    // Reciprocity: BDZGO -> AAAAA
    for (int i = 0; i < 5; i++) send($sformatf("rcp%0d", i), ct[i], pt[i], 1'b1);
    check("rcp_pos", cur_pos(), pk(0, 0, 5));

    // Invalid letter
    in_valid = 1'b1;
    data_in  = 5'd26;
    tick();
    in_valid = 1'b0;
    check("inv_vld", 16'(out_valid), 16'd1);
    check("inv_err", 16'(out_err), 16'd1);
    check("inv_out", 16'(data_out), 16'd26);
    check("inv_pos", cur_pos(), pk(0, 0, 5));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("inv_idle", 16'(in_ready), 16'd1);

    // Backpressure: A from AAA -> B, held for 10 cycles with a letter waiting
    load(0, 0, 0, 1'b0);
    in_valid = 1'b1;
    data_in  = 5'd0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_vld", 16'(out_valid), 16'd1);
    check("bp_err_clr", 16'(out_err), 16'd0);
    in_valid = 1'b1;
    data_in  = 5'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_hold%0d", i), 16'(data_out), 16'd1);
      check($sformatf("bp_nrdy%0d", i), 16'(in_ready), 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_pos", cur_pos(), pk(0, 0, 1));
    check("bp_idle", 16'(in_ready), 16'd1);

    // Reset during FWD aborts the letter
    in_valid = 1'b1;
    data_in  = 5'd0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #2;
    check("rfwd_pos", cur_pos(), pk(0, 0, 0));
    check("rfwd_dout", 16'(data_out), 16'd0);
    check("rfwd_vld", 16'(out_valid), 16'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rfwd_quiet%0d", i), 16'(out_valid), 16'd0);
    end
    check("rfwd_rdy", 16'(in_ready), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
